// File: rtl/traffic_pkg.sv
// Shared definitions for the four-lane traffic phase scheduler: phase
// encodings, lane indices and lamp-code helpers.
package traffic_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_ALLRED = 2'd3
    } phase_t;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE_NS1 = 2'd0;
    localparam lane_t LANE_NS2 = 2'd1;
    localparam lane_t LANE_EW1 = 2'd2;
    localparam lane_t LANE_EW2 = 2'd3;

    // Lamp decoder code: GREEN n -> 2n+1, YELLOW n -> 2n+2, otherwise dark.
    function automatic logic [3:0] light_code_f(phase_t ph, lane_t lane);
        logic [3:0] code;
        case (ph)
            PH_GREEN:  code = {1'b0, lane, 1'b0} + 4'd1;
            PH_YELLOW: code = {1'b0, lane, 1'b0} + 4'd2;
            default:   code = 4'd0;
        endcase
        return code;
    endfunction

    function automatic logic [NUM_LANES-1:0] lane_onehot_f(lane_t lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_lane_picker.sv
// Combinational next-lane selection: lowest-index emergency lane wins,
// otherwise rotate over demand starting after the last green lane.
module lane_picker
    import traffic_pkg::*;
(
    input  logic [3:0] emerg,
    input  logic [3:0] demand,
    input  lane_t      last,
    output logic       valid,
    output lane_t      lane
);

    lane_t idx_s;

    // Priority pick; loops run high-to-low so the best candidate is written last.
    always_comb begin
        valid = 1'b0;
        lane  = last;
        idx_s = last;
        if (emerg != 4'd0) begin
            valid = 1'b1;
            for (int i = NUM_LANES - 1; i >= 0; i--) begin
                lane = emerg[i] ? lane_t'(i) : lane;
            end
        end else begin
            valid = (demand != 4'd0);
            // Offset 4 wraps to the last lane itself, making it eligible last.
            for (int i = NUM_LANES; i >= 1; i--) begin
                idx_s = last + lane_t'(i);
                lane  = demand[idx_s] ? idx_s : lane;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Tick-timed phase sequencer for a four-lane intersection: round-robin
// green grants with min/max green, yellow, all-red and emergency preemption.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TW        = 8,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] demand,
    input  logic [3:0] congest,
    input  logic [3:0] emerg,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [1:0] active_lane,
    output logic [1:0] phase,
    output logic [3:0] light_code,
    output logic       lane_switch
);

    localparam logic [TW:0] MIN_C = (TW+1)'(MIN_GREEN);
    localparam logic [TW:0] MAX_C = (TW+1)'(MAX_GREEN);
    localparam logic [TW:0] YEL_C = (TW+1)'(YELLOW_T);
    localparam logic [TW:0] ARD_C = (TW+1)'(ALLRED_T);

    phase_t        phase_r;
    phase_t        phase_nx_s;
    logic [TW-1:0] cnt_r;
    logic [TW-1:0] cnt_nx_s;
    logic [TW-1:0] c_sat_s;
    logic [TW:0]   c_s;
    lane_t         lane_r;
    lane_t         lane_nx_s;
    logic          grant_s;
    logic          pick_valid_s;
    lane_t         pick_lane_s;
    logic [3:0]    lane_oh_s;

    lane_picker u_picker (
        .emerg  (emerg),
        .demand (demand),
        .last   (lane_r),
        .valid  (pick_valid_s),
        .lane   (pick_lane_s)
    );

    // Next-state logic; every transition only happens on a tick cycle.
    always_comb begin
        phase_nx_s = phase_r;
        cnt_nx_s   = cnt_r;
        lane_nx_s  = lane_r;
        grant_s    = 1'b0;
        lane_oh_s  = lane_onehot_f(lane_r);
        c_s        = {1'b0, cnt_r} + {{TW{1'b0}}, 1'b1};
        // Saturate so a long emergency hold cannot wrap the counter.
        c_sat_s    = c_s[TW] ? cnt_r : c_s[TW-1:0];
        if (tick) begin
            case (phase_r)
                PH_GREEN: begin
                    if (emerg[lane_r]) begin
                        cnt_nx_s = c_sat_s;
                    end else if ((emerg & ~lane_oh_s) != 4'd0) begin
                        phase_nx_s = PH_YELLOW;
                        cnt_nx_s   = {TW{1'b0}};
                    end else if (c_s >= MAX_C) begin
                        phase_nx_s = PH_YELLOW;
                        cnt_nx_s   = {TW{1'b0}};
                    end else if ((c_s >= MIN_C) && !congest[lane_r]) begin
                        phase_nx_s = PH_YELLOW;
                        cnt_nx_s   = {TW{1'b0}};
                    end else begin
                        cnt_nx_s = c_sat_s;
                    end
                end
                PH_YELLOW: begin
                    if (c_s >= YEL_C) begin
                        phase_nx_s = PH_ALLRED;
                        cnt_nx_s   = {TW{1'b0}};
                    end else begin
                        cnt_nx_s = c_sat_s;
                    end
                end
                PH_ALLRED: begin
                    if (c_s >= ARD_C) begin
                        cnt_nx_s = {TW{1'b0}};
                        if (pick_valid_s) begin
                            phase_nx_s = PH_GREEN;
                            lane_nx_s  = pick_lane_s;
                            grant_s    = 1'b1;
                        end else begin
                            phase_nx_s = PH_IDLE;
                        end
                    end else begin
                        cnt_nx_s = c_sat_s;
                    end
                end
                PH_IDLE: begin
                    // Clearance was already served before idling.
                    if (pick_valid_s) begin
                        phase_nx_s = PH_GREEN;
                        lane_nx_s  = pick_lane_s;
                        cnt_nx_s   = {TW{1'b0}};
                        grant_s    = 1'b1;
                    end else begin
                        cnt_nx_s = {TW{1'b0}};
                    end
                end
                default: begin
                    phase_nx_s = PH_ALLRED;
                    cnt_nx_s   = {TW{1'b0}};
                end
            endcase
        end else begin
            phase_nx_s = phase_r;
        end
    end

    // State and lamp registers; lamps follow the next phase so they change with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r     <= PH_ALLRED;
            cnt_r       <= {TW{1'b0}};
            lane_r      <= LANE_EW2;
            green       <= 4'd0;
            yellow      <= 4'd0;
            light_code  <= 4'd0;
            lane_switch <= 1'b0;
        end else begin
            phase_r     <= phase_nx_s;
            cnt_r       <= cnt_nx_s;
            lane_r      <= lane_nx_s;
            green       <= (phase_nx_s == PH_GREEN)  ? lane_onehot_f(lane_nx_s) : 4'd0;
            yellow      <= (phase_nx_s == PH_YELLOW) ? lane_onehot_f(lane_nx_s) : 4'd0;
            light_code  <= light_code_f(phase_nx_s, lane_nx_s);
            lane_switch <= grant_s;
        end
    end

    assign phase       = phase_r;
    assign active_lane = lane_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: phase timing, round robin,
// congestion, emergency preemption, tick hold and asynchronous reset.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] demand = 4'd0;
    logic [3:0] congest = 4'd0;
    logic [3:0] emerg = 4'd0;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [1:0] active_lane;
    logic [1:0] phase;
    logic [3:0] light_code;
    logic       lane_switch;

    int total = 0;
    int bad   = 0;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .demand      (demand),
        .congest     (congest),
        .emerg       (emerg),
        .green       (green),
        .yellow      (yellow),
        .active_lane (active_lane),
        .phase       (phase),
        .light_code  (light_code),
        .lane_switch (lane_switch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inv();
        total++;
        assert (!((green != 4'd0) && (yellow != 4'd0)) && $onehot0(green) && $onehot0(yellow)) else begin
            bad++;
            $error("FAIL lamp_invariant observed green=%b yellow=%b expected exclusive one-hot", green, yellow);
        end
    endtask

    // Each tick occupies one clock; outputs are sampled at the following negedge.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            inv();
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, single-lane demand, then fall back to IDLE.
        demand = 4'b0001;
        do_reset();
        chk("rst_phase", 8'(phase), 8'd3);
        chk("rst_lane", 8'(active_lane), 8'd3);
        chk("rst_green", 8'(green), 8'd0);
        chk("rst_yellow", 8'(yellow), 8'd0);
        chk("rst_code", 8'(light_code), 8'd0);
        chk("rst_switch", 8'(lane_switch), 8'd0);
        tick_n(1);
        chk("allred_hold", 8'(phase), 8'd3);
        tick_n(1);
        chk("g0_phase", 8'(phase), 8'd1);
        chk("g0_green", 8'(green), 8'b0001);
        chk("g0_code", 8'(light_code), 8'd1);
        chk("g0_switch", 8'(lane_switch), 8'd1);
        chk("g0_lane", 8'(active_lane), 8'd0);
        cyc(1);
        chk("g0_switch_pulse", 8'(lane_switch), 8'd0);
        demand = 4'b0000;
        tick_n(4);
        chk("g0_min_hold", 8'(green), 8'b0001);
        tick_n(1);
        chk("y0_phase", 8'(phase), 8'd2);
        chk("y0_yellow", 8'(yellow), 8'b0001);
        chk("y0_code", 8'(light_code), 8'd2);
        tick_n(2);
        chk("y0_hold", 8'(phase), 8'd2);
        tick_n(1);
        chk("ar0_phase", 8'(phase), 8'd3);
        chk("ar0_code", 8'(light_code), 8'd0);
        tick_n(1);
        chk("ar0_hold", 8'(phase), 8'd3);
        tick_n(1);
        chk("idle_phase", 8'(phase), 8'd0);

        // No tick for 50 cycles: nothing moves even with demand present.
        demand = 4'b0001;
        cyc(50);
        chk("idle_notick_phase", 8'(phase), 8'd0);
        chk("idle_notick_green", 8'(green), 8'd0);
        tick_n(1);
        chk("idle_grant_green", 8'(green), 8'b0001);
        chk("idle_grant_switch", 8'(lane_switch), 8'd1);
        cyc(50);
        chk("green_notick_phase", 8'(phase), 8'd1);
        chk("green_notick_green", 8'(green), 8'b0001);

        // Full demand: grants 0,1,2,3,0 ten ticks apart.
        demand = 4'b1111;
        do_reset();
        tick_n(2);
        chk("rr_first_lane", 8'(active_lane), 8'd0);
        chk("rr_first_switch", 8'(lane_switch), 8'd1);
        for (int k = 1; k <= 4; k++) begin
            tick_n(9);
            chk("rr_pre_phase", 8'(phase), 8'd3);
            chk("rr_pre_switch", 8'(lane_switch), 8'd0);
            tick_n(1);
            chk("rr_green", 8'(green), 8'(4'b0001 << (k % 4)));
            chk("rr_lane", 8'(active_lane), 8'(k % 4));
            chk("rr_switch", 8'(lane_switch), 8'd1);
        end

        // Congestion held: green capped at exactly 20 ticks.
        demand  = 4'b0001;
        congest = 4'b0001;
        do_reset();
        tick_n(2);
        tick_n(19);
        chk("cong_hold19", 8'(phase), 8'd1);
        tick_n(1);
        chk("cong_max_phase", 8'(phase), 8'd2);
        chk("cong_max_yellow", 8'(yellow), 8'b0001);

        // Congestion drops at tick 8: yellow on that tick.
        do_reset();
        tick_n(2);
        tick_n(7);
        chk("cdrop_hold", 8'(phase), 8'd1);
        congest = 4'b0000;
        tick_n(1);
        chk("cdrop_phase", 8'(phase), 8'd2);

        // Emergency preemption to lane 2, held beyond MAX_GREEN.
        do_reset();
        tick_n(2);
        tick_n(1);
        emerg = 4'b0100;
        tick_n(1);
        chk("em_yellow0", 8'(yellow), 8'b0001);
        tick_n(2);
        chk("em_yellow_full", 8'(phase), 8'd2);
        tick_n(1);
        chk("em_allred", 8'(phase), 8'd3);
        tick_n(1);
        chk("em_allred_full", 8'(phase), 8'd3);
        tick_n(1);
        chk("em_green2", 8'(green), 8'b0100);
        chk("em_code5", 8'(light_code), 8'd5);
        chk("em_lane2", 8'(active_lane), 8'd2);
        tick_n(25);
        chk("em_hold_past_max", 8'(green), 8'b0100);
        emerg = 4'b0000;
        tick_n(1);
        chk("em_release_yellow", 8'(yellow), 8'b0100);
        chk("em_release_code", 8'(light_code), 8'd6);

        // Asynchronous reset mid-green darkens lamps at once.
        do_reset();
        tick_n(2);
        chk("pre_rst_green", 8'(green), 8'b0001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_green", 8'(green), 8'd0);
        chk("async_rst_phase", 8'(phase), 8'd3);
        chk("async_rst_lane", 8'(active_lane), 8'd3);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
